// File: rtl/sync_fifo_ptr_ctrl_pkg.sv
// Shared sizing for the synchronous FIFO pointer controller.
// FIFO_DEPTH is normally supplied by sync_fifo_defines.vh; the fallback keeps standalone builds working.
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 16
`endif

package sync_fifo_ptr_ctrl_pkg;

   localparam int unsigned DEFAULT_FIFO_DEPTH = `FIFO_DEPTH;

   // Pointers carry one bit more than the memory address to tell full from empty.
   function automatic int unsigned ptr_width(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// Binary pointer counter with increment and synchronous clear; wraps modulo 2^WIDTH.
module fifo_ptr_counter
   import sync_fifo_ptr_ctrl_pkg::*;
#(
   parameter int WIDTH = ptr_width($clog2(DEFAULT_FIFO_DEPTH))
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/sync_fifo_ptr_ctrl.sv
// Write/read pointer owner for the synchronous FIFO: gates requests against full/empty,
// drives memory strobes/addresses and keeps sticky overflow/underflow flags.
module sync_fifo_ptr_ctrl
   import sync_fifo_ptr_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr_en,
   input  logic                  i_rd_en,
   input  logic                  i_flush,
   input  logic                  i_clr_err,
   input  logic                  i_full,
   input  logic                  i_empty,
   output logic [ADDR_WIDTH:0]   o_wr_addr,
   output logic [ADDR_WIDTH:0]   o_rd_addr,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_waddr,
   output logic                  o_mem_re,
   output logic [ADDR_WIDTH-1:0] o_mem_raddr,
   output logic                  o_rd_data_valid,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_acc;
   logic             rd_acc;
   logic             rd_vld_p1;
   logic             ovf_set;
   logic             unf_set;

   // i_empty is one cycle stale after the last read, so the live pointer compare guards reads.
   assign wr_acc  = i_wr_en & ~i_full & ~i_flush & ~reset;
   assign rd_acc  = i_rd_en & ~i_empty & (wr_ptr != rd_ptr) & ~i_flush & ~reset;
   assign ovf_set = i_wr_en & i_full & ~i_flush;
   assign unf_set = i_rd_en & ~rd_acc & ~i_flush;

   fifo_ptr_counter #(.WIDTH(PTR_W)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (i_flush),
      .inc   (wr_acc),
      .count (wr_ptr)
   );

   fifo_ptr_counter #(.WIDTH(PTR_W)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (i_flush),
      .inc   (rd_acc),
      .count (rd_ptr)
   );

   // p0 -> p1: read strobe to data valid, plus sticky error flags (set wins over clear)
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_vld_p1   <= 1'b0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         rd_vld_p1 <= rd_acc;
         if (ovf_set) begin
            o_overflow <= 1'b1;
         end else if (i_clr_err) begin
            o_overflow <= 1'b0;
         end
         if (unf_set) begin
            o_underflow <= 1'b1;
         end else if (i_clr_err) begin
            o_underflow <= 1'b0;
         end
      end
   end

   assign o_wr_addr       = wr_ptr;
   assign o_rd_addr       = rd_ptr;
   assign o_mem_we        = wr_acc;
   assign o_mem_waddr     = wr_ptr[ADDR_WIDTH-1:0];
   assign o_mem_re        = rd_acc;
   assign o_mem_raddr     = rd_ptr[ADDR_WIDTH-1:0];
   assign o_rd_data_valid = rd_vld_p1;

endmodule
